// File: rtl/mw_add_pkg.sv
// Shared constants and state encoding for the multi-word sequential adder.
// Word width is fixed by the koggstone32 word adder.
package mw_add_pkg;

    localparam int MW_W     = 32;
    localparam int MW_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/koggstone32.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
// Purely combinational; used as the word-slice adder of mw_add_seq.
module koggstone32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] w_g [0:5];
    logic [31:0] w_p [0:5];
    logic [32:0] w_c;

    // Log2(32) prefix levels of group generate/propagate
    always_comb begin
        for (int l = 0; l < 6; l++) begin
            w_g[l] = '0;
            w_p[l] = '0;
        end
        w_g[0] = a & b;
        w_p[0] = a ^ b;
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << l)) begin
                    w_g[l+1][i] = w_g[l][i]
                                | (w_p[l][i] & w_g[l][i-(1<<l)]);
                    w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
                end else begin
                    w_g[l+1][i] = w_g[l][i];
                    w_p[l+1][i] = w_p[l][i];
                end
            end
        end
    end

    // Carry into bit i+1 folds the carry-in through the group propagate
    always_comb begin
        w_c = {w_g[5] | (w_p[5] & {32{ci}}), ci};
    end

    assign s  = w_p[0] ^ w_c[31:0];
    assign co = w_c[32];

endmodule

// File: rtl/mw_add_seq.sv
// Multi-word sequential adder: one W-bit word per cycle through a single
// koggstone32, carry held in a register between words.
module mw_add_seq
    import mw_add_pkg::*;
#(
    parameter int W     = MW_W,
    parameter int WORDS = MW_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               ci,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] s,
    output logic               co
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_idx;
    logic               r_cy;
    logic [W*WORDS-1:0] r_a;
    logic [W*WORDS-1:0] r_b;
    logic [W*WORDS-1:0] r_s;
    logic               r_co;
    logic [W-1:0]       w_aw;
    logic [W-1:0]       w_bw;
    logic [W-1:0]       w_sum;
    logic               w_co;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;

    // Select the current word of each latched operand
    always_comb begin
        w_aw   = r_a[r_idx*W +: W];
        w_bw   = r_b[r_idx*W +: W];
        w_last = (r_idx == LAST);
    end

    koggstone32 u_add (
        .a  (w_aw),
        .b  (w_bw),
        .ci (r_cy),
        .s  (w_sum),
        .co (w_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept, walk the words, wait for the consumer
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready  = 1'b1;
            ST_DONE: w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, per-word sum write-back and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cy  <= 1'b0;
            r_idx <= '0;
            r_s   <= '0;
            r_co  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cy  <= ci;
                        r_idx <= '0;
                    end
                end
                ST_RUN: begin
                    r_s[r_idx*W +: W] <= w_sum;
                    r_cy  <= w_co;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) r_co <= w_co;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign s         = r_s;
    assign co        = r_co;

endmodule

// File: tb/tb_mw_add_seq.sv
// Self-checking bench for mw_add_seq with an arithmetic reference model.
// Directed cases pin the model; random traffic exercises handshakes.
module tb_mw_add_seq;

    localparam int W     = 32;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         co;

    int checks;
    int errors;

    mw_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N:0] got,
                       input logic [N:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Reference model: idle / busy countdown / result-held, plain arithmetic
    logic         m_on;
    logic         m_idle;
    logic         m_valid;
    int           m_cnt;
    logic [N:0]   m_pend;
    logic [N-1:0] m_s;
    logic         m_co;

    initial begin
        m_on = 0; m_idle = 1; m_valid = 0; m_cnt = 0;
        m_pend = '0; m_s = '0; m_co = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_idle = 1; m_valid = 0; m_cnt = 0;
            m_s = '0; m_co = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
                m_cnt  = WORDS;
                m_idle = 0;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_s     = m_pend[N-1:0];
                m_co    = m_pend[N];
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
            m_idle  = 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, m_idle});
            chk("out_valid", {{N{1'b0}}, out_valid}, {{N{1'b0}}, m_valid});
            if (m_idle || m_valid) begin
                chk("s", {1'b0, s}, {1'b0, m_s});
                chk("co", {{N{1'b0}}, co}, {{N{1'b0}}, m_co});
            end
        end
    end

    task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb2,
                      input logic tci, input int hold,
                      output logic [N-1:0] rs, output logic rco,
                      output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        a = ta; b = tb2; ci = tci; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rs  = s;
        rco = co;
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", {{N{1'b0}}, out_valid}, 1);
            @(posedge clk); #1;
        end
        out_ready = 1;
        chk("done_no_in_ready", {{N{1'b0}}, in_ready}, 0);
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_after_ready", {{N{1'b0}}, in_ready}, 1);
    endtask

    logic [N-1:0] rs;
    logic         rco;
    int           lat;
    logic [N-1:0] ones;

    initial begin
        checks = 0; errors = 0;
        rst = 1; in_valid = 0; out_ready = 0;
        a = '0; b = '0; ci = 0;
        ones = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_in_ready", {{N{1'b0}}, in_ready}, 1);
        chk("rst_s", {co, s}, '0);

        op(5, 10, 1, 0, rs, rco, lat);
        chk("t1_s", {rco, rs}, 16);
        chk("t1_lat", lat, WORDS);

        op(128'h0000_0000_FFFF_FFFF, 1, 0, 0, rs, rco, lat);
        chk("t2_s", {rco, rs}, {1'b0, 128'h1_0000_0000});

        op(ones, 0, 1, 0, rs, rco, lat);
        chk("t3_s", {rco, rs}, {1'b1, {N{1'b0}}});

        op(127, 127, 1, 5, rs, rco, lat);
        chk("t4_s", {rco, rs}, 255);
        chk("t4_retained", {co, s}, 255);

        // New operands held during RUN must be ignored
        a = 100; b = 200; ci = 0; in_valid = 1;
        @(posedge clk); #1;
        a = 1000; b = 1; ci = 1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("t5_lat", lat, WORDS);
        chk("t5_first", {co, s}, 300);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("t5_idle", {{N{1'b0}}, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("t5_accepted", {{N{1'b0}}, in_ready}, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("t5_second", {co, s}, 1002);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        // Reset in the middle of RUN abandons the operation
        a = 999; b = 999; ci = 1; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("t6_in_ready", {{N{1'b0}}, in_ready}, 1);
        chk("t6_s", {co, s}, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t6_no_valid", {{N{1'b0}}, out_valid}, 0);
            @(posedge clk); #1;
        end
        op(37, 48, 0, 0, rs, rco, lat);
        chk("t6_s2", {rco, rs}, 85);

        // Random traffic with random back-pressure and rare resets
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 4) != 0;
            ci        = $urandom % 2;
            a = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom % 4)
                0: b = ~a;
                1: b = '0;
                default: b = {$urandom, $urandom, $urandom, $urandom};
            endcase
            rst = ($urandom % 97) == 0;
            @(posedge clk); #1;
        end
        rst = 0; in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
